// File: rtl/branch_resolve_pkg.sv
// Shared RV32I types for the control-transfer resolution stage.
// Provides the opcode and branch-condition encodings, the machine word, the
// resolve FSM state type, and the latched request / computed result records.
package branch_resolve_pkg;

  typedef logic [31:0] rv32i_word;

  typedef enum logic [6:0] {
    op_lui   = 7'b0110111,
    op_auipc = 7'b0010111,
    op_jal   = 7'b1101111,
    op_jalr  = 7'b1100111,
    op_br    = 7'b1100011,
    op_load  = 7'b0000011,
    op_store = 7'b0100011,
    op_imm   = 7'b0010011,
    op_reg   = 7'b0110011,
    op_csr   = 7'b1110011
  } rv32i_opcode;

  // 3'b010 and 3'b011 are not branch conditions; they resolve as not taken.
  typedef enum logic [2:0] {
    beq  = 3'b000,
    bne  = 3'b001,
    blt  = 3'b100,
    bge  = 3'b101,
    bltu = 3'b110,
    bgeu = 3'b111
  } branch_funct3_t;

  typedef enum logic [1:0] {BR_IDLE, BR_EVAL, BR_DONE} br_state_t;

  typedef struct packed {
    logic [6:0] opcode;
    logic [2:0] funct3;
    rv32i_word  pc;
    rv32i_word  imm;
    rv32i_word  rs1;
    rv32i_word  cmp_b;
    logic       pred_taken;
  } br_req_t;

  typedef struct packed {
    logic      taken;
    logic      mispredict;
    rv32i_word target;
    rv32i_word link;
  } br_res_t;

endpackage

// File: rtl/branch_resolve_if.sv
// Request / result bus of the branch resolve stage.
//  req_*  : one branch/jump per req_valid & req_ready handshake
//  out_*  : resolved result, held while out_valid until out_ready
// master = upstream issue + downstream consumer side, slave = resolve stage.
interface branch_resolve_if import branch_resolve_pkg::*; ();
  logic       req_valid;
  logic       req_ready;
  logic [6:0] req_opcode;
  logic [2:0] req_funct3;
  rv32i_word  req_pc;
  rv32i_word  req_imm;
  rv32i_word  req_rs1;
  rv32i_word  req_cmp_b;
  logic       req_pred_taken;

  logic       out_valid;
  logic       out_ready;
  logic       out_taken;
  logic       out_mispredict;
  rv32i_word  out_target;
  rv32i_word  out_link;

  modport master (
    output req_valid, req_opcode, req_funct3, req_pc, req_imm, req_rs1,
           req_cmp_b, req_pred_taken, out_ready,
    input  req_ready, out_valid, out_taken, out_mispredict, out_target, out_link
  );

  modport slave (
    input  req_valid, req_opcode, req_funct3, req_pc, req_imm, req_rs1,
           req_cmp_b, req_pred_taken, out_ready,
    output req_ready, out_valid, out_taken, out_mispredict, out_target, out_link
  );
endinterface

// File: rtl/branch_resolve_cmp.sv
// Branch condition evaluator.
//  funct3 : branch condition (branch_funct3_t encoding)
//  a, b   : rs1 and second compare operand
//  br_en  : condition true; 0 for non-branch funct3 codes
module branch_resolve_cmp import branch_resolve_pkg::*; (
  input  logic [2:0] funct3,
  input  rv32i_word  a,
  input  rv32i_word  b,
  output logic       br_en
);
  always_comb begin
    br_en = 1'b0;
    case (branch_funct3_t'(funct3))
      beq:     br_en = (a == b);
      bne:     br_en = (a != b);
      blt:     br_en = ($signed(a) <  $signed(b));
      bge:     br_en = ($signed(a) >= $signed(b));
      bltu:    br_en = (a <  b);
      bgeu:    br_en = (a >= b);
      default: br_en = 1'b0;
    endcase
  end
endmodule

// File: rtl/branch_resolve.sv
// Control-transfer resolution stage.
// Accepts one branch/jump, evaluates it one cycle later from the latched
// operands, and presents the actual next PC, link address and mispredict
// (against the static pc+imm prediction) until the consumer takes it.
//  clk, rst_n       : clock, synchronous active-low reset
//  br (slave)       : request / result bus
//  kill             : abort the in-flight op (older flush); ignored when idle
//  flush            : one-cycle pulse on the first result cycle if mispredicted
//  perf_br_total    : retired op_br count (saturating)
//  perf_br_mispred  : retired mispredicted op_br count (saturating)
module branch_resolve import branch_resolve_pkg::*; #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  branch_resolve_if.slave  br,
  input  logic             kill,
  output logic             flush,
  output logic [CNT_W-1:0] perf_br_total,
  output logic [CNT_W-1:0] perf_br_mispred
);
  br_state_t state_q, state_d;
  br_req_t   req_q;
  br_res_t   res_q, res_d;
  logic      flush_q;
  logic      br_en;
  logic      accept, retire;
  rv32i_word pc_imm, pc_4;

  branch_resolve_cmp u_cmp (
    .funct3 (req_q.funct3),
    .a      (req_q.rs1),
    .b      (req_q.cmp_b),
    .br_en  (br_en)
  );

  assign br.req_ready = rst_n & (state_q == BR_IDLE);
  assign accept       = br.req_valid & br.req_ready;
  // kill beats a same-cycle consumer handshake
  assign retire       = (state_q == BR_DONE) & br.out_ready & ~kill;

  always_comb begin
    state_d = state_q;
    case (state_q)
      BR_IDLE: if (accept) state_d = BR_EVAL;
      BR_EVAL: state_d = kill ? BR_IDLE : BR_DONE;
      BR_DONE: if (kill || br.out_ready) state_d = BR_IDLE;
      default: state_d = BR_IDLE;
    endcase
  end

  // Resolution from latched operands; all adds wrap mod 2^32.
  assign pc_imm = req_q.pc + req_q.imm;
  assign pc_4   = req_q.pc + 32'd4;

  always_comb begin
    res_d            = '0;
    res_d.link       = pc_4;
    res_d.target     = pc_4;
    case (req_q.opcode)
      op_br: begin
        res_d.taken      = br_en;
        res_d.target     = br_en ? pc_imm : pc_4;
        res_d.mispredict = (br_en != req_q.pred_taken);
      end
      op_jal: begin
        res_d.taken      = 1'b1;
        res_d.target     = pc_imm;
        res_d.mispredict = ~req_q.pred_taken;
      end
      op_jalr: begin
        // Predicted target pc+imm never models a register target.
        res_d.taken      = 1'b1;
        res_d.target     = (req_q.rs1 + req_q.imm) & ~32'h1;
        res_d.mispredict = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= BR_IDLE;
      req_q           <= '0;
      res_q           <= '0;
      flush_q         <= 1'b0;
      perf_br_total   <= '0;
      perf_br_mispred <= '0;
    end else begin
      state_q <= state_d;
      if (accept)
        req_q <= '{opcode: br.req_opcode, funct3: br.req_funct3, pc: br.req_pc,
                   imm: br.req_imm, rs1: br.req_rs1, cmp_b: br.req_cmp_b,
                   pred_taken: br.req_pred_taken};
      if (state_q == BR_EVAL && !kill)
        res_q <= res_d;
      // Set only on the EVAL->DONE edge, so backpressure cannot re-pulse it.
      flush_q <= (state_q == BR_EVAL) & ~kill & res_d.mispredict;
      if (retire && req_q.opcode == op_br) begin
        if (perf_br_total != '1)
          perf_br_total <= perf_br_total + 1'b1;
        if (res_q.mispredict && perf_br_mispred != '1)
          perf_br_mispred <= perf_br_mispred + 1'b1;
      end
    end
  end

  assign flush             = flush_q & ~kill;
  assign br.out_valid      = (state_q == BR_DONE);
  assign br.out_taken      = res_q.taken;
  assign br.out_mispredict = res_q.mispredict;
  assign br.out_target     = res_q.target;
  assign br.out_link       = res_q.link;

endmodule

// File: tb/tb_branch_resolve.sv
// Bench for branch_resolve: directed scenarios with literal expectations plus
// randomized traffic, all checked each cycle against a transaction-level model.
module tb_branch_resolve;
  import branch_resolve_pkg::*;

  localparam int CNT_W = 4;
  localparam int SAT   = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             kill = 1'b0;
  logic             flush;
  logic [CNT_W-1:0] perf_tot, perf_mis;

  branch_resolve_if ifc ();

  branch_resolve #(.CNT_W(CNT_W)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .br              (ifc.slave),
    .kill            (kill),
    .flush           (flush),
    .perf_br_total   (perf_tot),
    .perf_br_mispred (perf_mis)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---- reference: what one instruction must resolve to ----
  typedef struct {
    bit        taken;
    bit        mis;
    bit [31:0] target;
    bit [31:0] link;
    bit        is_br;
  } exp_t;

  function automatic exp_t ref_eval(bit [6:0] op, bit [2:0] f3, bit [31:0] pc,
                                    bit [31:0] imm, bit [31:0] rs1, bit [31:0] b, bit pred);
    exp_t e;
    bit   c;
    e.link  = pc + 32'd4;
    e.is_br = (op == op_br);
    if (op == op_br) begin
      case (f3)
        3'd0:    c = (rs1 == b);
        3'd1:    c = (rs1 != b);
        3'd4:    c = ($signed(rs1) < $signed(b));
        3'd5:    c = !($signed(rs1) < $signed(b));
        3'd6:    c = (rs1 < b);
        3'd7:    c = !(rs1 < b);
        default: c = 1'b0;
      endcase
      e.taken  = c;
      e.target = c ? pc + imm : pc + 32'd4;
      e.mis    = (c != pred);
    end else if (op == op_jal) begin
      e.taken = 1'b1; e.target = pc + imm; e.mis = !pred;
    end else if (op == op_jalr) begin
      e.taken = 1'b1; e.target = (rs1 + imm) & 32'hFFFF_FFFE; e.mis = 1'b1;
    end else begin
      e.taken = 1'b0; e.target = pc + 32'd4; e.mis = 1'b0;
    end
    return e;
  endfunction

  // ---- model state: is an op in flight, and how many cycles since accept ----
  bit   m_busy = 0, m_clean = 0, m_started = 0;
  int   m_age = 0, m_tot = 0, m_mis = 0;
  exp_t m_exp;

  // Compare, then advance the model with the inputs the next edge will see.
  initial begin
    forever begin
      @(negedge clk);
      if (m_started) begin
        chk("req_ready", ifc.req_ready, rst_n && !m_busy);
        chk("out_valid", ifc.out_valid, m_busy && m_age >= 2);
        chk("flush", flush, m_busy && m_age == 2 && m_exp.mis && !kill);
        chk("perf_br_total", perf_tot, m_tot);
        chk("perf_br_mispred", perf_mis, m_mis);
        if (m_busy && m_age >= 2) begin
          chk("out_taken", ifc.out_taken, m_exp.taken);
          chk("out_mispredict", ifc.out_mispredict, m_exp.mis);
          chk("out_target", ifc.out_target, m_exp.target);
          chk("out_link", ifc.out_link, m_exp.link);
        end else if (m_clean) begin
          chk("reset_outs", {ifc.out_taken, ifc.out_mispredict,
                             |ifc.out_target, |ifc.out_link}, 0);
        end
      end
      if (!rst_n) begin
        m_busy = 0; m_tot = 0; m_mis = 0; m_clean = 1; m_started = 1;
      end else if (!m_busy) begin
        if (ifc.req_valid) begin
          m_busy = 1; m_age = 1;
          m_exp = ref_eval(ifc.req_opcode, ifc.req_funct3, ifc.req_pc, ifc.req_imm,
                           ifc.req_rs1, ifc.req_cmp_b, ifc.req_pred_taken);
        end
      end else if (kill) begin
        m_busy = 0;
      end else if (m_age == 1) begin
        m_age = 2; m_clean = 0;
      end else if (ifc.out_ready) begin
        if (m_exp.is_br) begin
          if (m_tot < SAT) m_tot++;
          if (m_exp.mis && m_mis < SAT) m_mis++;
        end
        m_busy = 0;
      end else begin
        m_age++;
      end
    end
  end

  // ---- drivers ----
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic send(bit [6:0] op, bit [2:0] f3, bit [31:0] pc, bit [31:0] imm,
                      bit [31:0] rs1, bit [31:0] b, bit pred);
    int n = 0;
    step();
    ifc.req_opcode = op; ifc.req_funct3 = f3; ifc.req_pc = pc; ifc.req_imm = imm;
    ifc.req_rs1 = rs1; ifc.req_cmp_b = b; ifc.req_pred_taken = pred;
    ifc.req_valid = 1'b1;
    do begin @(negedge clk); n++; end while (!ifc.req_ready && n < 50);
    chk("accept", ifc.req_ready, 1);
    step();
    ifc.req_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    do begin @(negedge clk); n++; end while (!ifc.out_valid && n < 50);
    chk("done_timeout", ifc.out_valid, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    ifc.req_valid = 0; ifc.req_opcode = '0; ifc.req_funct3 = '0; ifc.req_pc = '0;
    ifc.req_imm = '0; ifc.req_rs1 = '0; ifc.req_cmp_b = '0; ifc.req_pred_taken = 0;
    ifc.out_ready = 1;

    // model pins
    e = ref_eval(op_br, 3'd0, 32'h100, 32'h20, 5, 5, 0);
    chk("ref_beq", {e.taken, e.mis, e.target}, {2'b11, 32'h120});
    e = ref_eval(op_br, 3'd4, 32'h0, 32'h8, 32'hFFFF_FFFF, 1, 0);
    chk("ref_blt", e.taken, 1);
    e = ref_eval(op_br, 3'd6, 32'h0, 32'h8, 32'hFFFF_FFFF, 1, 0);
    chk("ref_bltu", {e.taken, e.target}, {1'b0, 32'h4});
    e = ref_eval(op_jalr, 3'd0, 32'h200, 32'h4, 32'h1003, 0, 0);
    chk("ref_jalr", e.target, 32'h1006);
    e = ref_eval(op_jal, 3'd0, 32'hFFFF_FFFC, 32'h8, 0, 0, 1);
    chk("ref_wrap", {e.target[7:0], e.link[7:0], 7'd0, e.mis}, {8'h04, 8'h00, 8'h00});
    e = ref_eval(op_br, 3'd2, 32'h0, 32'h8, 1, 1, 0);
    chk("ref_bad_f3", e.taken, 0);

    repeat (3) step();
    rst_n = 1;

    // beq: latency and first-cycle flush
    send(op_br, 3'd0, 32'h100, 32'h20, 5, 5, 0);
    @(negedge clk); chk("beq_eval_not_valid", ifc.out_valid, 0);
    @(negedge clk);
    chk("beq_valid", ifc.out_valid, 1);
    chk("beq_target", ifc.out_target, 32'h120);
    chk("beq_mis", ifc.out_mispredict, 1);
    chk("beq_flush", flush, 1);
    @(negedge clk);
    chk("beq_flush_once", flush, 0);
    chk("beq_perf", perf_tot, 1);

    // jalr: register target, forced mispredict, not counted
    send(op_jalr, 3'd0, 32'h200, 32'h4, 32'h1003, 0, 0);
    wait_done();
    chk("jalr_target", ifc.out_target, 32'h1006);
    chk("jalr_link", ifc.out_link, 32'h204);
    chk("jalr_mis", ifc.out_mispredict, 1);
    step(); step();
    chk("jalr_perf", perf_tot, 1);

    // signed vs unsigned compare
    send(op_br, 3'd4, 32'h300, 32'h40, 32'hFFFF_FFFF, 1, 0);
    wait_done();
    chk("blt_taken", ifc.out_taken, 1);
    send(op_br, 3'd6, 32'h300, 32'h40, 32'hFFFF_FFFF, 1, 0);
    wait_done();
    chk("bltu_taken", ifc.out_taken, 0);
    chk("bltu_target", ifc.out_target, 32'h304);

    // jal with wrap
    send(op_jal, 3'd0, 32'hFFFF_FFF0, 32'h20, 0, 0, 1);
    wait_done();
    chk("jal_wrap_target", ifc.out_target, 32'h10);
    chk("jal_wrap_link", ifc.out_link, 32'hFFFF_FFF4);

    // backpressure
    step(); ifc.out_ready = 0;
    send(op_br, 3'd0, 32'h400, 32'h10, 7, 7, 0);
    wait_done();
    chk("bp_flush_first", flush, 1);
    repeat (5) begin
      @(negedge clk);
      chk("bp_flush_held_low", flush, 0);
      chk("bp_target_stable", ifc.out_target, 32'h410);
      chk("bp_req_ready", ifc.req_ready, 0);
    end
    step(); ifc.out_ready = 1;
    send(op_br, 3'd1, 32'h500, 32'h8, 1, 1, 0);   // accepted after release
    wait_done();
    step(); step();
    chk("bp_perf", perf_tot, 5);

    // kill in EVAL
    send(op_br, 3'd1, 32'h600, 32'h8, 1, 2, 0);
    kill = 1; step(); kill = 0;
    @(negedge clk);
    chk("kill_eval_valid", ifc.out_valid, 0);
    chk("kill_eval_perf", perf_tot, 5);

    // kill in first DONE cycle with out_ready=1
    send(op_br, 3'd1, 32'h700, 32'h8, 1, 2, 0);
    step(); kill = 1;
    @(negedge clk); chk("kill_done_flush", flush, 0);
    step(); kill = 0;
    @(negedge clk);
    chk("kill_done_valid", ifc.out_valid, 0);
    chk("kill_done_perf", perf_tot, 5);

    // kill while idle does not block acceptance
    kill = 1;
    send(op_br, 3'd0, 32'h800, 32'h8, 3, 3, 1);
    kill = 0;
    wait_done();
    chk("idle_kill_taken", ifc.out_taken, 1);

    // saturation
    for (int i = 0; i < 20; i++) begin
      send(op_br, 3'd1, 32'h1000 + i * 4, 32'h40, i, i + 1, 0);
      wait_done();
    end
    step(); step();
    chk("sat_total", perf_tot, SAT);
    chk("sat_mispred", perf_mis, SAT);

    // reset mid-EVAL
    send(op_br, 3'd0, 32'h900, 32'h8, 1, 1, 0);
    rst_n = 0; step(); rst_n = 1;
    @(negedge clk);
    chk("rst_total", perf_tot, 0);
    chk("rst_mispred", perf_mis, 0);
    chk("rst_valid", ifc.out_valid, 0);
    chk("rst_target", ifc.out_target, 0);

    // random traffic
    for (int c = 0; c < 1500; c++) begin
      step();
      ifc.req_valid = $urandom_range(0, 1);
      case ($urandom_range(0, 6))
        0, 1, 2: ifc.req_opcode = op_br;
        3:       ifc.req_opcode = op_jal;
        4:       ifc.req_opcode = op_jalr;
        5:       ifc.req_opcode = op_reg;
        default: ifc.req_opcode = 7'($urandom);
      endcase
      ifc.req_funct3 = 3'($urandom);
      ifc.req_pc  = $urandom;
      ifc.req_imm = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 255)) - 128;
      ifc.req_rs1 = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 3)) - 2;
      ifc.req_cmp_b = ($urandom_range(0, 3) == 0) ? ifc.req_rs1
                    : (($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 3)) - 2);
      ifc.req_pred_taken = $urandom_range(0, 1);
      ifc.out_ready = ($urandom_range(0, 2) != 0);
      kill  = ($urandom_range(0, 11) == 0);
      rst_n = ($urandom_range(0, 299) != 0);
    end
    step();
    ifc.req_valid = 0; kill = 0; rst_n = 1; ifc.out_ready = 1;
    repeat (10) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
